// File: rtl/voting_pkg.sv
// Shared definitions for the voter session controller: FSM state codes,
// session result codes, voter ID width and the authenticator verdict rule.
package voting_pkg;

    localparam int ID_W = 8;

    typedef logic [ID_W-1:0] voter_id_t;
    typedef logic [2:0]      result_t;
    typedef logic [2:0]      state_t;

    // Controller states; EVAL is not a state of its own, it happens on the
    // edge that ends the last WAIT cycle.
    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_ENTRY   = 3'd1;
    localparam state_t S_REQ     = 3'd2;
    localparam state_t S_WAIT    = 3'd3;
    localparam state_t S_BALLOT  = 3'd4;
    localparam state_t S_LOCKOUT = 3'd5;

    // Session outcome codes reported on result_code.
    localparam result_t RC_NONE     = 3'd0;
    localparam result_t RC_ACCEPTED = 3'd1;
    localparam result_t RC_INVALID  = 3'd2;
    localparam result_t RC_ALREADY  = 3'd3;
    localparam result_t RC_TIMEOUT  = 3'd4;
    localparam result_t RC_CAST_OK  = 3'd5;
    localparam result_t RC_LOCKED   = 3'd6;
    localparam result_t RC_ABORT    = 3'd7;

    typedef struct packed {
        logic valid_voter;
        logic already_voted;
        logic authenticated;
    } auth_flags_t;

    // Turns the three authenticator flags into a verdict. An unknown voter
    // outranks everything, a repeat voter outranks an authenticated flag,
    // and a known voter that is neither repeat nor authenticated is treated
    // as invalid.
    function automatic result_t classify_response(input auth_flags_t flags);
        if (!flags.valid_voter)
            return RC_INVALID;
        else if (flags.already_voted)
            return RC_ALREADY;
        else if (flags.authenticated)
            return RC_ACCEPTED;
        else
            return RC_INVALID;
    endfunction

endpackage

// File: rtl/voter_session_controller_if.sv
// Request/response bundle between the session controller (master) and the
// voter authenticator (slave).
interface voter_session_controller_if;
    import voting_pkg::*;

    voter_id_t voter_id_out;
    logic      authenticate_voter;
    logic      valid_voter;
    logic      already_voted;
    logic      authenticated;

    modport master (
        output voter_id_out,
        output authenticate_voter,
        input  valid_voter,
        input  already_voted,
        input  authenticated
    );

    modport slave (
        input  voter_id_out,
        input  authenticate_voter,
        output valid_voter,
        output already_voted,
        output authenticated
    );

endinterface

// File: rtl/session_down_counter.sv
// Loadable down-counter with a zero flag. The controller shares one instance
// for the response wait, the ballot window and the lockout period.
module session_down_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over counting; the count parks at zero until reloaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/voter_session_controller.sv
// Voter session controller: collects a two-nibble voter ID, requests
// authentication, opens a timed ballot window and issues a single vote strobe,
// locking the keypad out after repeated failed authentications.
// Optional build macro CAST_CONFIRM_EN: a cast needs a second press with the
// same candidate before the vote strobe is issued.
module voter_session_controller
    import voting_pkg::*;
#(
    parameter int NUM_CAND       = 4,
    parameter int RESP_LATENCY   = 1,
    parameter int BALLOT_TIMEOUT = 1000,
    parameter int MAX_FAILS      = 3,
    parameter int LOCK_CYCLES    = 500
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        system_enable,
    input  logic                        key_valid,
    input  logic [3:0]                  key_nibble,
    input  logic                        key_clear,
    voter_session_controller_if.master  auth,
    input  logic [$clog2(NUM_CAND)-1:0] candidate_sel,
    input  logic                        cast_btn,
    output logic                        ballot_open,
    output logic                        vote_strobe,
    output logic [$clog2(NUM_CAND)-1:0] vote_candidate,
    output logic [2:0]                  result_code,
    output logic                        lockout,
    output logic                        busy
);

    localparam int MAX_LOAD =
        (BALLOT_TIMEOUT > LOCK_CYCLES) ?
            ((BALLOT_TIMEOUT > RESP_LATENCY) ? BALLOT_TIMEOUT : RESP_LATENCY) :
            ((LOCK_CYCLES > RESP_LATENCY) ? LOCK_CYCLES : RESP_LATENCY);
    localparam int TIMER_W = $clog2(MAX_LOAD + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);

    localparam logic [TIMER_W-1:0] WAIT_LOAD   = TIMER_W'(RESP_LATENCY - 1);
    localparam logic [TIMER_W-1:0] BALLOT_LOAD = TIMER_W'(BALLOT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCK_CYCLES - 1);

    state_t              state;
    state_t              next_state;
    result_t             result_reg;
    result_t             next_result;
    voter_id_t           voter_id;
    logic [FAIL_W-1:0]   fail_cnt;
    auth_flags_t         flags;
    result_t             verdict;
    logic                fail_hit;
    logic                cast_req;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_value;
    logic                timer_zero;
    logic                latch_high;
    logic                latch_low;
    logic                clear_id;
    logic                fire;
    logic                fail_inc;
    logic                fail_clear;

`ifdef CAST_CONFIRM_EN
    logic                        confirm_pending;
    logic [$clog2(NUM_CAND)-1:0] pending_cand;
    logic                        relatch;
`endif

    assign flags    = {auth.valid_voter, auth.already_voted, auth.authenticated};
    assign verdict  = classify_response(flags);
    assign fail_hit = (int'(fail_cnt) + 1) >= MAX_FAILS;
    assign cast_req = cast_btn && (int'(candidate_sel) < NUM_CAND);

    session_down_counter #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Next-state, outcome and side-effect decode for the session FSM.
    // Dropping system_enable aborts a session in progress; in IDLE it just
    // keeps a new session from starting, so the last outcome is not lost.
    always_comb begin
        next_state  = state;
        next_result = result_reg;
        timer_load  = 1'b0;
        timer_value = '0;
        latch_high  = 1'b0;
        latch_low   = 1'b0;
        clear_id    = 1'b0;
        fire        = 1'b0;
        fail_inc    = 1'b0;
        fail_clear  = 1'b0;
`ifdef CAST_CONFIRM_EN
        relatch     = 1'b0;
`endif
        if (!system_enable && state != S_IDLE && state != S_LOCKOUT) begin
            next_state  = S_IDLE;
            next_result = RC_ABORT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (system_enable && key_valid) begin
                        latch_high = 1'b1;
                        next_state = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (key_clear) begin
                        clear_id   = 1'b1;
                        next_state = S_IDLE;
                    end else if (key_valid) begin
                        latch_low  = 1'b1;
                        next_state = S_REQ;
                    end
                end
                S_REQ: begin
                    timer_load  = 1'b1;
                    timer_value = WAIT_LOAD;
                    next_state  = S_WAIT;
                end
                S_WAIT: begin
                    if (timer_zero) begin
                        if (verdict == RC_ACCEPTED) begin
                            next_result = RC_ACCEPTED;
                            fail_clear  = 1'b1;
                            timer_load  = 1'b1;
                            timer_value = BALLOT_LOAD;
                            next_state  = S_BALLOT;
                        end else if (fail_hit) begin
                            next_result = RC_LOCKED;
                            fail_inc    = 1'b1;
                            timer_load  = 1'b1;
                            timer_value = LOCK_LOAD;
                            next_state  = S_LOCKOUT;
                        end else begin
                            next_result = verdict;
                            fail_inc    = 1'b1;
                            next_state  = S_IDLE;
                        end
                    end
                end
                S_BALLOT: begin
`ifdef CAST_CONFIRM_EN
                    if (cast_req) begin
                        if (confirm_pending && candidate_sel == pending_cand)
                            fire = 1'b1;
                        else
                            relatch = 1'b1;
                    end
`else
                    fire = cast_req;
`endif
                    if (fire) begin
                        next_result = RC_CAST_OK;
                        next_state  = S_IDLE;
                    end else if (timer_zero) begin
                        next_result = RC_TIMEOUT;
                        next_state  = S_IDLE;
                    end
                end
                S_LOCKOUT: begin
                    if (timer_zero) begin
                        fail_clear = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                default: begin
                    next_state = S_IDLE;
                end
            endcase
        end
    end

    // State and last-outcome registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            result_reg <= RC_NONE;
        end else begin
            state      <= next_state;
            result_reg <= next_result;
        end
    end

    // Voter ID assembly, high nibble first; held until the next entry starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            voter_id <= '0;
        else if (clear_id)
            voter_id <= '0;
        else if (latch_high)
            voter_id[7:4] <= key_nibble;
        else if (latch_low)
            voter_id[3:0] <= key_nibble;
    end

    // Consecutive failed authentications; any success or an ended lockout clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fail_cnt <= '0;
        else if (fail_clear)
            fail_cnt <= '0;
        else if (fail_inc)
            fail_cnt <= fail_cnt + 1'b1;
    end

    // One-cycle vote strobe to the tally logic with its registered candidate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_strobe    <= 1'b0;
            vote_candidate <= '0;
        end else begin
            vote_strobe <= fire;
            if (fire)
                vote_candidate <= candidate_sel;
        end
    end

`ifdef CAST_CONFIRM_EN
    // First press latches a candidate; a different second press re-latches it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            confirm_pending <= 1'b0;
            pending_cand    <= '0;
        end else if (next_state != S_BALLOT) begin
            confirm_pending <= 1'b0;
        end else if (relatch) begin
            confirm_pending <= 1'b1;
            pending_cand    <= candidate_sel;
        end
    end
`endif

    assign auth.authenticate_voter = (state == S_REQ);
    assign auth.voter_id_out       = voter_id;
    assign ballot_open             = (state == S_BALLOT);
    assign lockout                 = (state == S_LOCKOUT);
    assign busy                    = (state != S_IDLE) && (state != S_ENTRY);
    assign result_code             = result_reg;

endmodule
